instr_fetch: RTL

//   Instruction-supply stage directly upstream of simple_cpu. Holds a writable program store of

---
 rtl/instr_fetch.sv | 137 +++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction-supply stage for simple_cpu: writable program store, PC stepping and per-class word hold.
// Optional feature: define IFETCH_LOOP_EN to restart at word 0 instead of halting.
module instr_fetch #(
   parameter int INSTR_WIDTH = 20,
   parameter int PC_BITS     = 5,
   parameter int HOLD_STD    = 3,
   parameter int HOLD_LOAD   = 4,
   parameter int HOLD_STORE  = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   prog_we,
   input  logic [PC_BITS-1:0]     prog_addr,
   input  logic [INSTR_WIDTH-1:0] prog_data,
   output logic [INSTR_WIDTH-1:0] instruction,
   output logic [PC_BITS-1:0]     pc,
   output logic                   busy,
   output logic                   done,
   output logic                   prog_err
);

   localparam int DEPTH     = 2 ** PC_BITS;
   localparam int HOLD_MAX0 = (HOLD_STD > HOLD_LOAD) ? HOLD_STD : HOLD_LOAD;
   localparam int HOLD_MAX  = (HOLD_MAX0 > HOLD_STORE) ? HOLD_MAX0 : HOLD_STORE;
   localparam int CNT_W     = $clog2(HOLD_MAX + 2);

   localparam logic [PC_BITS-1:0] PC_MAX  = '1;
   localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, ISSUE, HALT} state_t;

   state_t                 state, state_nxt;
   logic [INSTR_WIDTH-1:0] mem [DEPTH];
   logic [INSTR_WIDTH-1:0] instr_nxt;
   logic [INSTR_WIDTH-1:0] first_word;
   logic [INSTR_WIDTH-1:0] next_word;
   logic [PC_BITS-1:0]     pc_nxt;
   logic [CNT_W-1:0]       cnt, cnt_nxt;
   logic                   store_we;

   function automatic logic is_nop(input logic [INSTR_WIDTH-1:0] w);
      return w[INSTR_WIDTH-1 -: 2] == 2'b00;
   endfunction

   function automatic logic [CNT_W-1:0] hold_of(input logic [INSTR_WIDTH-1:0] w);
      case (w[INSTR_WIDTH-1 -: 2])
         2'b10:   return CNT_W'(HOLD_LOAD);
         2'b11:   return CNT_W'(HOLD_STORE);
         default: return CNT_W'(HOLD_STD);
      endcase
   endfunction

   assign store_we   = prog_we && (state != ISSUE);
   assign first_word = mem[0];
   assign next_word  = mem[pc + 1'b1];

   // NOTE: the program store has no reset; its contents must survive rst and a reset port would block RAM mapping.
   always_ff @(posedge clk) begin
      if (store_we) mem[prog_addr] <= prog_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         instruction <= '0;
         pc          <= '0;
         cnt         <= '0;
         prog_err    <= 1'b0;
      end else begin
         state       <= state_nxt;
         instruction <= instr_nxt;
         pc          <= pc_nxt;
         cnt         <= cnt_nxt;
         prog_err    <= prog_we && (state == ISSUE);
      end
   end

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      state_nxt = state;
      instr_nxt = instruction;
      pc_nxt    = pc;
      cnt_nxt   = cnt;
      unique case (state)
         IDLE, HALT: begin
            // A simultaneous write wins over start; the first word gets one extra cycle for CU reset exit.
            if (start && !prog_we) begin
               pc_nxt = '0;
               if (is_nop(first_word)) begin
                  state_nxt = HALT;
                  instr_nxt = '0;
               end else begin
                  state_nxt = ISSUE;
                  instr_nxt = first_word;
                  cnt_nxt   = hold_of(first_word) + CNT_ONE;
               end
            end
         end
         ISSUE: begin
            if (cnt != CNT_ONE) begin
               cnt_nxt = cnt - CNT_ONE;
            end else if (pc == PC_MAX || is_nop(next_word)) begin
`ifdef IFETCH_LOOP_EN
               pc_nxt = '0;
               if (is_nop(first_word)) begin
                  state_nxt = HALT;
                  instr_nxt = '0;
               end else begin
                  instr_nxt = first_word;
                  cnt_nxt   = hold_of(first_word);
               end
`else
               if (pc != PC_MAX) pc_nxt = pc + 1'b1;
               state_nxt = HALT;
               instr_nxt = '0;
`endif
            end else begin
               pc_nxt    = pc + 1'b1;
               instr_nxt = next_word;
               cnt_nxt   = hold_of(next_word);
            end
         end
         default: begin
            state_nxt = IDLE;
            instr_nxt = '0;
         end
      endcase
   end

   always_comb begin
      busy = (state == ISSUE);
      done = (state == HALT);
   end

endmodule
